// File: rtl/bird_mem_arbiter_pkg.sv
// Shared types and defaults for the bird memory arbiter.
package bird_mem_pkg;

  localparam int unsigned DEF_AW = 16;
  localparam int unsigned DEF_DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  // Width of the burst counter: clog2(max_burst), never less than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/bird_mem_arbiter_if.sv
// Two-master request/grant bus plus the single-port memory side.
interface bird_mem_arbiter_if
  import bird_mem_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
) ();

  logic          m0_req;
  logic          m0_we;
  logic          m0_lock;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic          m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  // Environment side: the two bus masters and the memory's read port.
  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m0_gnt, m0_rdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_gnt, m1_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );

  // Arbiter side.
  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m0_gnt, m0_rdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_gnt, m1_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

endinterface

// File: rtl/bird_mem_arbiter.sv
// Registered round-robin arbiter between the bird CPU (master 0) and a
// second bus master (master 1) for the shared single-port memory.
module bird_mem_arbiter
  import bird_mem_pkg::*;
#(
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  bird_mem_arbiter_if.slave  bus
);

  localparam int unsigned    CW      = cnt_width(MAX_BURST);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_BURST - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          last_q;
  logic          beat;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;
  logic          we_mux;

  // A beat is a granted cycle in which the owner is still requesting.
  always_comb begin
    beat = ((state_q == GNT0) && bus.m0_req) || ((state_q == GNT1) && bus.m1_req);
  end

  // State, burst counter and round-robin history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
        if (state_q == GNT0)      last_q <= 1'b0;
        else if (state_q == GNT1) last_q <= 1'b1;
      end else if (beat && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Next grant: round-robin on ties, preempt a full unlocked burst.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.m0_req && bus.m1_req) state_d = last_q ? GNT0 : GNT1;
        else if (bus.m0_req)          state_d = GNT0;
        else if (bus.m1_req)          state_d = GNT1;
      end
      GNT0: begin
        if (!bus.m0_req)
          state_d = bus.m1_req ? GNT1 : IDLE;
        else if (bus.m1_req && !bus.m0_lock && (cnt_q == CNT_MAX))
          state_d = GNT1;
      end
      GNT1: begin
        if (!bus.m1_req)
          state_d = bus.m0_req ? GNT0 : IDLE;
        else if (bus.m0_req && !bus.m1_lock && (cnt_q == CNT_MAX))
          state_d = GNT0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory mux and grant decode, driven only from the registered state.
  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    we_mux    = 1'b0;
    case (state_q)
      GNT0: begin
        addr_mux  = bus.m0_addr;
        wdata_mux = bus.m0_wdata;
        we_mux    = bus.m0_we;
      end
      GNT1: begin
        addr_mux  = bus.m1_addr;
        wdata_mux = bus.m1_wdata;
        we_mux    = bus.m1_we;
      end
      default: ;
    endcase
    bus.mem_addr  = addr_mux;
    bus.mem_wdata = wdata_mux;
    bus.mem_we    = we_mux;
    bus.m0_gnt    = (state_q == GNT0);
    bus.m1_gnt    = (state_q == GNT1);
    bus.m0_rdata  = (state_q == GNT0) ? bus.mem_rdata : '0;
    bus.m1_rdata  = (state_q == GNT1) ? bus.mem_rdata : '0;
  end

endmodule

// File: tb/tb_bird_mem_arbiter.sv
// Scoreboard bench for bird_mem_arbiter: the driver pushes a hand-computed
// expected record per cycle, the monitor pops and compares mid-cycle.
module tb_bird_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bird_mem_arbiter_if #(.AW(16), .DW(16)) bus ();

  bird_mem_arbiter #(.AW(16), .DW(16), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural memory: combinational read, write on the rising edge.
  logic [15:0] mem [0:65535];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr];

  typedef struct packed {
    logic [3:0]  tst;
    logic [7:0]  cyc;
    logic        g0;
    logic        g1;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rd0;
    logic [15:0] rd1;
    logic [1:0]  cnt;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  exp_t       mon_a;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] cur_tst = '0;
  logic [7:0] cur_cyc = '0;

  // Monitor: compare whatever the DUT presents against the next expected record.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      mon_a = '{tst: mon_e.tst, cyc: mon_e.cyc, g0: bus.m0_gnt, g1: bus.m1_gnt,
                we: bus.mem_we, addr: bus.mem_addr, wdata: bus.mem_wdata,
                rd0: bus.m0_rdata, rd1: bus.m1_rdata, cnt: dut.cnt_q};
      n_tests++;
      if (mon_a !== mon_e) begin
        n_fail++;
        $display("FAIL t%0d.c%0d g0/g1/we addr wdata rd0 rd1 cnt: got %b%b%b %h %h %h %h %0d want %b%b%b %h %h %h %h %0d",
                 mon_e.tst, mon_e.cyc,
                 mon_a.g0, mon_a.g1, mon_a.we, mon_a.addr, mon_a.wdata, mon_a.rd0, mon_a.rd1, mon_a.cnt,
                 mon_e.g0, mon_e.g1, mon_e.we, mon_e.addr, mon_e.wdata, mon_e.rd0, mon_e.rd1, mon_e.cnt);
      end
    end
  end

  task automatic set_m0(input logic r, input logic w, input logic l,
                        input logic [15:0] a, input logic [15:0] d);
    bus.m0_req = r; bus.m0_we = w; bus.m0_lock = l; bus.m0_addr = a; bus.m0_wdata = d;
  endtask

  task automatic set_m1(input logic r, input logic w, input logic l,
                        input logic [15:0] a, input logic [15:0] d);
    bus.m1_req = r; bus.m1_we = w; bus.m1_lock = l; bus.m1_addr = a; bus.m1_wdata = d;
  endtask

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic ex(input logic g0, input logic g1, input logic we,
                    input logic [15:0] addr, input logic [15:0] wdata,
                    input logic [15:0] rd0, input logic [15:0] rd1, input logic [1:0] cnt);
    q.push_back('{tst: cur_tst, cyc: cur_cyc, g0: g0, g1: g1, we: we, addr: addr,
                  wdata: wdata, rd0: rd0, rd1: rd1, cnt: cnt});
    cur_cyc = cur_cyc + 8'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    ex(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 2'd0);
  endtask

  task automatic new_test(input logic [3:0] t);
    cur_tst = t;
    cur_cyc = '0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    mem[16'h0010] = 16'hBEEF;
    mem[16'h0020] = 16'h1111;
    mem[16'h0030] = 16'h2222;

    rst_n = 1'b0;
    set_m0(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_m1(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk);
    #1;

    // Reset state
    new_test(4'd0);
    ex_idle();
    rst_n = 1'b1;

    // Single m0 read, one cycle of grant latency
    new_test(4'd1);
    set_m0(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0);
    ex_idle();
    ex(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 16'h0, 2'd0);
    set_m0(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0);
    ex(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 16'h0, 2'd1);
    ex_idle();
    rst_n = 1'b0;
    ex_idle();
    rst_n = 1'b1;

    // Simultaneous requests after reset: 4 beats each, m0 first, no gap
    new_test(4'd2);
    set_m0(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0);
    set_m1(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0);
    ex_idle();
    for (int i = 0; i < 12; i++) begin
      if (((i / 4) % 2) == 0)
        ex(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0, 16'h1111, 16'h0, 2'(i % 4));
      else
        ex(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0, 16'h0, 16'h2222, 2'(i % 4));
    end
    set_m0(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0);
    set_m1(1'b0, 1'b0, 1'b0, 16'h0030, 16'h0);
    ex(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0, 16'h0, 16'h2222, 2'd0);
    ex_idle();

    // m1 two-beat write, back to IDLE, then m0 reads the location
    new_test(4'd3);
    set_m1(1'b1, 1'b1, 1'b0, 16'h0100, 16'h1234);
    ex_idle();
    ex(1'b0, 1'b1, 1'b1, 16'h0100, 16'h1234, 16'h0, 16'h0, 2'd0);
    ex(1'b0, 1'b1, 1'b1, 16'h0100, 16'h1234, 16'h0, 16'h1234, 2'd1);
    set_m1(1'b0, 1'b0, 1'b0, 16'h0100, 16'h1234);
    ex(1'b0, 1'b1, 1'b0, 16'h0100, 16'h1234, 16'h0, 16'h1234, 2'd2);
    ex_idle();
    set_m0(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0);
    ex_idle();
    ex(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0, 16'h1234, 16'h0, 2'd0);
    set_m0(1'b0, 1'b0, 1'b0, 16'h0100, 16'h0);
    ex(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0, 16'h1234, 16'h0, 2'd1);
    ex_idle();

    // Lock holds m0 for 10 contended beats; handover on lock release,
    // then a direct handback when m1 drops with m0 still pending
    new_test(4'd4);
    set_m0(1'b1, 1'b0, 1'b1, 16'h0020, 16'h0);
    ex_idle();
    set_m1(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0);
    for (int i = 0; i < 10; i++)
      ex(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0, 16'h1111, 16'h0, (i < 3) ? 2'(i) : 2'd3);
    set_m0(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0);
    ex(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0, 16'h1111, 16'h0, 2'd3);
    set_m1(1'b0, 1'b0, 1'b0, 16'h0030, 16'h0);
    ex(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0, 16'h0, 16'h2222, 2'd0);
    set_m0(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0);
    ex(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0, 16'h1111, 16'h0, 2'd0);
    ex_idle();

    // Reset during the third beat of an m1 write burst
    new_test(4'd5);
    set_m1(1'b1, 1'b1, 1'b0, 16'h0200, 16'h5555);
    ex_idle();
    ex(1'b0, 1'b1, 1'b1, 16'h0200, 16'h5555, 16'h0, 16'h0, 2'd0);
    ex(1'b0, 1'b1, 1'b1, 16'h0200, 16'h5555, 16'h0, 16'h5555, 2'd1);
    rst_n = 1'b0;
    ex(1'b0, 1'b1, 1'b1, 16'h0200, 16'h5555, 16'h0, 16'h5555, 2'd2);
    rst_n = 1'b1;
    set_m0(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0);
    ex_idle();
    ex(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0, 16'h1111, 16'h0, 2'd0);
    set_m0(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0);
    set_m1(1'b0, 1'b0, 1'b0, 16'h0200, 16'h5555);
    ex(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0, 16'h1111, 16'h0, 2'd1);
    ex_idle();

    // Uncontended m0 keeps the grant; counter saturates at 3
    new_test(4'd6);
    set_m0(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0);
    ex_idle();
    for (int i = 0; i < 20; i++)
      ex(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 16'h0, (i < 3) ? 2'(i) : 2'd3);
    set_m0(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0);
    ex(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 16'h0, 2'd3);
    ex_idle();

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected records left, want 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
